ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter PRIO_MODE, default 0, where 0 is round-robin and 1 gives port 1 fixed priority.
REQ-004 SHALL have port clk_qzt  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  in  1  high permits new grants; in-flight access always completes.
REQ-007 SHALL have ports p0_req, p1_req  in  1  request strobes; port 0 = CPU, port 1 = loader/debug.
REQ-008 SHALL have ports p0_we, p1_we  in  1  write (1) or read (0) qualifier for the matching req.
REQ-009 SHALL have ports p0_addr, p1_addr  in  ADDR_W  access address.
REQ-010 SHALL have ports p0_wdata, p1_wdata  in  DATA_W  write data.
REQ-011 SHALL have ports p0_ack, p1_ack  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  out  DATA_W  registered read data, valid while an ack is high.
REQ-013 SHALL have port ram_addr  out  ADDR_W  RAM address.
REQ-014 SHALL have port ram_wdata  out  DATA_W  RAM write data.
REQ-015 SHALL have port ram_we  out  1  RAM write enable.
REQ-016 SHALL have port ram_rdata  in  DATA_W  RAM read data; the RAM has one-cycle synchronous read latency.
REQ-017 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-018 SHALL have port dbg_interface  out  24  {state[3:0], last_grant, owner, 2'b0, ram_addr[7:0], rdata[7:0]}.

Function
REQ-019 SHALL implement the FSM IDLE -> ACCESS -> (RD_WAIT, for reads only) -> DONE -> IDLE.
REQ-020 SHALL, in IDLE with en=1 and at least one req high, choose an owner, latch that port's we/addr/wdata, and enter ACCESS on the next edge.
REQ-021 SHALL, with PRIO_MODE=0, grant the sole requester; on a tie, grant the port other than last_grant; last_grant updates on each grant.
REQ-022 SHALL, with PRIO_MODE=1, grant port 1 on a tie, and still record last_grant.
REQ-023 SHALL, in ACCESS, drive ram_addr and ram_wdata from the latched values, and drive ram_we=1 only for a write, for exactly one cycle.
REQ-024 SHALL, for a read, pass through RD_WAIT and capture ram_rdata into rdata on the edge that leaves RD_WAIT.
REQ-025 SHALL, in DONE, assert only the owner's ack for one cycle; rdata holds its value until the next read capture.
REQ-026 SHALL give these latencies, taking request sampled at edge N: write ack high after edge N+2; read ack high after edge N+3.
REQ-027 SHALL require the requester to hold req/we/addr/wdata until ack; inputs changing after the grant edge are ignored.
REQ-028 SHALL treat req still high in the cycle after ack as a new request; back-to-back transactions therefore have one IDLE cycle between them.
REQ-029 SHALL not abort a granted access when its req drops, and SHALL still issue its ack.
REQ-030 SHALL not grant in IDLE while en=0; requests simply wait.
REQ-031 SHALL keep ram_we=0 in IDLE, RD_WAIT and DONE; ram_addr holds its last value.
REQ-032 SHALL pass addresses through unmodified, with no wrap or offset; 0xFF is a legal address.
REQ-033 SHALL serve a single requester held high continuously, once per 3 (write) or 4 (read) cycles, and SHALL never starve it under PRIO_MODE=0.

Reset
REQ-034 SHALL, on reset low, immediately set state=IDLE, ram_we=0, p0_ack=p1_ack=0, ram_addr=0, ram_wdata=0, rdata=0, busy=0, owner=0, last_grant=1; any in-flight access is abandoned without an ack.
REQ-035 SHALL treat reset deassertion as taking effect at the next clk_qzt edge; the first tie after reset goes to port 0.

Structure
REQ-036 SHALL take its state encoding (IDLE=0, ACCESS=1, RD_WAIT=2, DONE=3) and PRIO_RR/PRIO_FIXED constants from shared package ram_arb_pkg.
REQ-037 SHALL place grant selection in combinational sub-module arb_pick (inputs: two reqs, last_grant, mode; outputs: grant_valid, grant_idx).

Verification
REQ-038 SHALL be checked by: p0 read addr 0x10, RAM holds 0x3C -> p0_ack after edge N+3, rdata=0x3C, p1_ack never high.
REQ-039 SHALL be checked by: p1 write 0xA5 to 0xFF -> ram_we high exactly one cycle with ram_addr=0xFF and ram_wdata=0xA5; p1_ack after edge N+2.
REQ-040 SHALL be checked by: both ports held requesting for 6 transactions, PRIO_MODE=0 -> grant order 0,1,0,1,0,1; with PRIO_MODE=1 -> p1 takes every tie.
REQ-041 SHALL be checked by: en=0 while p0_req=1 for 5 cycles -> no grant and busy=0; raising en -> grant on the next edge.
REQ-042 SHALL be checked by: reset pulsed low during ACCESS of a write -> ram_we falls immediately, no ack, state=IDLE.
REQ-043 SHALL be checked by: p0 drops req one cycle after grant -> access completes and p0_ack still pulses.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding and priority modes.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // Debug bus carries the state as a 4-bit field.
  function automatic logic [3:0] state_code(arb_state_t s);
    return {2'b00, s};
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus of the two-port RAM arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              p0_req;
  logic              p1_req;
  logic              p0_we;
  logic              p1_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_ack;
  logic              p1_ack;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
    input  p0_wdata, p1_wdata, ram_rdata,
    output p0_ack, p1_ack, rdata, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
    output p0_wdata, p1_wdata, ram_rdata,
    input  p0_ack, p1_ack, rdata, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/ram_arbiter_pick.sv
// Combinational grant selection between the two request ports.
module arb_pick
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic mode,
  output logic grant_valid,
  output logic grant_idx
);

  // On a tie, fixed mode favours port 1; round-robin favours whoever did not win last.
  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = 1'b0;
    if (req0 && req1) begin
      grant_idx = mode ? 1'b1 : ~last_grant;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Acks are registered out of DONE, so they appear in the IDLE cycle that follows.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic         clk_qzt,
  input  logic         reset,
  input  logic         en,
  ram_arbiter_if.slave bus,
  output logic         busy,
  output logic [23:0]  dbg_interface
);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              take;
  logic              owner;
  logic              last_grant;
  logic              lat_we;
  logic              grant_valid;
  logic              grant_idx;
  logic              prio_fixed;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [7:0]        dbg_addr;
  logic [7:0]        dbg_rdata;

  assign prio_fixed = (PRIO_MODE == PRIO_FIXED);

  arb_pick u_pick (
    .req0        (bus.p0_req),
    .req1        (bus.p1_req),
    .last_grant  (last_grant),
    .mode        (prio_fixed),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_we    = grant_idx ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = grant_idx ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant_idx ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clk_qzt or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (en && grant_valid) begin
          take      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = lat_we ? DONE : RD_WAIT;
      RD_WAIT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The RAM address/data registers double as the latched request; they hold after the access.
  always_ff @(posedge clk_qzt or negedge reset) begin
    if (!reset) begin
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      lat_we        <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_we    <= 1'b0;
      bus.p0_ack    <= 1'b0;
      bus.p1_ack    <= 1'b0;
      bus.rdata     <= '0;
    end else begin
      bus.ram_we <= 1'b0;
      bus.p0_ack <= 1'b0;
      bus.p1_ack <= 1'b0;
      if (take) begin
        owner         <= grant_idx;
        last_grant    <= grant_idx;
        lat_we        <= sel_we;
        bus.ram_addr  <= sel_addr;
        bus.ram_wdata <= sel_wdata;
        bus.ram_we    <= sel_we;
      end
      if (state == RD_WAIT) begin
        bus.rdata <= bus.ram_rdata;
      end
      if (state == DONE) begin
        bus.p0_ack <= ~owner;
        bus.p1_ack <= owner;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_addr  = 8'(bus.ram_addr);
  assign dbg_rdata = 8'(bus.rdata);

  assign dbg_interface = {state_code(state), last_grant, owner, 2'b00, dbg_addr, dbg_rdata};

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table of single transactions plus multi-cycle corner sequences.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  logic        clk_qzt = 1'b0;
  logic        reset;
  logic        en;
  logic        busy0;
  logic        busy1;
  logic [23:0] dbg0;
  logic [23:0] dbg1;
  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  int          total = 0;
  int          bad = 0;
  vec_t        vecs [6];

  always #5 clk_qzt = ~clk_qzt;

  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
  ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(PRIO_RR)) dut0 (
    .clk_qzt       (clk_qzt),
    .reset         (reset),
    .en            (en),
    .bus           (bus0.slave),
    .busy          (busy0),
    .dbg_interface (dbg0)
  );

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(PRIO_FIXED)) dut1 (
    .clk_qzt       (clk_qzt),
    .reset         (reset),
    .en            (en),
    .bus           (bus1.slave),
    .busy          (busy1),
    .dbg_interface (dbg1)
  );

  // Synchronous RAM models, preloaded with 0x3C at 0x10 whenever reset is low at an edge.
  always @(posedge clk_qzt) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= (i == 16) ? 8'h3C : 8'h00;
        mem1[i] <= (i == 16) ? 8'h3C : 8'h00;
      end
    end else begin
      if (bus0.ram_we) mem0[bus0.ram_addr] <= bus0.ram_wdata;
      if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    end
    bus0.ram_rdata <= mem0[bus0.ram_addr];
    bus1.ram_rdata <= mem1[bus1.ram_addr];
  end

  task automatic tick();
    @(posedge clk_qzt);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic port, input logic req, input logic we,
                                input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      bus0.p1_req = req; bus0.p1_we = we; bus0.p1_addr = addr; bus0.p1_wdata = wdata;
    end else begin
      bus0.p0_req = req; bus0.p0_we = we; bus0.p0_addr = addr; bus0.p0_wdata = wdata;
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int         lat = 0;
    int         we_cnt = 0;
    logic       wrong_ack = 1'b0;
    logic [7:0] we_addr = 8'h00;
    logic [7:0] we_data = 8'h00;
    logic [7:0] got_rdata = 8'h00;
    apply_stimulus(v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick();
      if (bus0.ram_we) begin
        we_cnt++;
        we_addr = bus0.ram_addr;
        we_data = bus0.ram_wdata;
      end
      if (v.port ? bus0.p0_ack : bus0.p1_ack) wrong_ack = 1'b1;
      if (v.port ? bus0.p1_ack : bus0.p0_ack) begin
        lat = i;
        got_rdata = bus0.rdata;
      end
    end
    apply_stimulus(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output($sformatf("vec%0d_latency", idx), 32'(lat), v.we ? 32'd3 : 32'd4);
    check_output($sformatf("vec%0d_other_ack", idx), 32'(wrong_ack), 32'd0);
    check_output($sformatf("vec%0d_we_pulses", idx), 32'(we_cnt), 32'(v.we));
    check_output($sformatf("vec%0d_ram_addr", idx), 32'(bus0.ram_addr), 32'(v.addr));
    if (v.we) begin
      check_output($sformatf("vec%0d_we_addr", idx), 32'(we_addr), 32'(v.addr));
      check_output($sformatf("vec%0d_we_data", idx), 32'(we_data), 32'(v.wdata));
    end else begin
      check_output($sformatf("vec%0d_rdata", idx), 32'(got_rdata), 32'(v.exp_rdata));
    end
    tick();
    check_output($sformatf("vec%0d_idle_after", idx),
                 32'({busy0, bus0.p0_ack, bus0.p1_ack}), 32'd0);
  endtask

  task automatic run_tie(input logic which, input string tag);
    int   got [$];
    logic a0;
    logic a1;
    if (which) begin
      bus1.p0_req = 1'b1; bus1.p0_we = 1'b1; bus1.p0_addr = 8'h20; bus1.p0_wdata = 8'h11;
      bus1.p1_req = 1'b1; bus1.p1_we = 1'b1; bus1.p1_addr = 8'h21; bus1.p1_wdata = 8'h22;
    end else begin
      bus0.p0_req = 1'b1; bus0.p0_we = 1'b1; bus0.p0_addr = 8'h20; bus0.p0_wdata = 8'h11;
      bus0.p1_req = 1'b1; bus0.p1_we = 1'b1; bus0.p1_addr = 8'h21; bus0.p1_wdata = 8'h22;
    end
    for (int i = 0; i < 60 && got.size() < 6; i++) begin
      tick();
      a0 = which ? bus1.p0_ack : bus0.p0_ack;
      a1 = which ? bus1.p1_ack : bus0.p1_ack;
      if (a0) got.push_back(0);
      if (a1) got.push_back(1);
    end
    if (which) begin
      bus1.p0_req = 1'b0; bus1.p1_req = 1'b0;
    end else begin
      bus0.p0_req = 1'b0; bus0.p1_req = 1'b0;
    end
    tick();
    tick();
    check_output({tag, "_ack_count"}, 32'(got.size()), 32'd6);
    for (int k = 0; k < got.size(); k++) begin
      check_output($sformatf("%s_grant%0d", tag, k), 32'(got[k]), which ? 32'd1 : 32'(k % 2));
    end
  endtask

  initial begin
    int   lat;
    logic flag;

    reset = 1'b0;
    en    = 1'b1;
    bus0.p0_req = 1'b0; bus0.p0_we = 1'b0; bus0.p0_addr = 8'h00; bus0.p0_wdata = 8'h00;
    bus0.p1_req = 1'b0; bus0.p1_we = 1'b0; bus0.p1_addr = 8'h00; bus0.p1_wdata = 8'h00;
    bus1.p0_req = 1'b0; bus1.p0_we = 1'b0; bus1.p0_addr = 8'h00; bus1.p0_wdata = 8'h00;
    bus1.p1_req = 1'b0; bus1.p1_we = 1'b0; bus1.p1_addr = 8'h00; bus1.p1_wdata = 8'h00;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h5A, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C};

    tick();
    tick();
    check_output("reset_dbg", 32'(dbg0), 32'h0008_0000);
    check_output("reset_outs", 32'({busy0, bus0.ram_we, bus0.p0_ack, bus0.p1_ack}), 32'd0);
    check_output("reset_ram_bus", 32'({bus0.ram_addr, bus0.ram_wdata, bus0.rdata}), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    $display("[TB] enable gating");
    en = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy0 || dbg0[23:20] != 4'd0) flag = 1'b1;
    end
    check_output("en0_no_grant", 32'(flag), 32'd0);
    en = 1'b1;
    tick();
    check_output("en1_grant_state", 32'(dbg0[23:20]), 32'd1);
    check_output("en1_busy", 32'(busy0), 32'd1);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (bus0.p0_ack) lat = i;
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output("en1_ack_latency", 32'(lat), 32'd3);
    check_output("en1_rdata", 32'(bus0.rdata), 32'h3C);
    tick();

    $display("[TB] req dropped after grant");
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
    tick();
    check_output("drop_grant_state", 32'(dbg0[23:20]), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    lat = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      if (bus0.p0_ack) lat = i;
    end
    check_output("drop_ack_latency", 32'(lat), 32'd3);
    check_output("drop_rdata", 32'(bus0.rdata), 32'hA5);
    tick();

    $display("[TB] reset during write access");
    apply_stimulus(1'b0, 1'b1, 1'b1, 8'h33, 8'h77);
    tick();
    check_output("rst_pre_we", 32'(bus0.ram_we), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_we_low", 32'(bus0.ram_we), 32'd0);
    check_output("rst_state_idle", 32'(dbg0[23:20]), 32'd0);
    check_output("rst_busy_addr", 32'({busy0, bus0.ram_addr}), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #2;
    reset = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus0.p0_ack || bus0.p1_ack) flag = 1'b1;
    end
    check_output("rst_no_ack", 32'(flag), 32'd0);

    $display("[TB] tie sequences");
    run_tie(1'b0, "rr");
    run_tie(1'b1, "fixed");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
